// File: rtl/gpu_rasterizer_if.sv
// Op-FIFO read, sprite-ROM read and framebuffer write signals between the rasterizer
// (master) and its surroundings (slave).
interface gpu_rasterizer_if #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned SPRITE_ADDR_WIDTH = 12
);
  localparam int unsigned FbAddrWidth = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  typedef struct packed {
    logic [10:0]                  x;
    logic [10:0]                  y;
    logic [10:0]                  width;
    logic [10:0]                  height;
    logic                         color;
    logic                         mem_en;
    logic [SPRITE_ADDR_WIDTH-1:0] mem_addr;
    logic                         scale;
  } gpu_op_t;

  gpu_op_t                      op;
  logic                         op_empty;
  logic                         op_rd_en;
  logic [SPRITE_ADDR_WIDTH-1:0] sprite_rd_addr;
  logic [1:0]                   sprite_rd_data;
  logic                         fb_wr_en;
  logic [FbAddrWidth-1:0]       fb_wr_addr;
  logic                         fb_wr_data;
  logic                         busy;

  modport master (
    input  op, op_empty, sprite_rd_data,
    output op_rd_en, sprite_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data, busy
  );

  modport slave (
    output op, op_empty, sprite_rd_data,
    input  op_rd_en, sprite_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data, busy
  );
endinterface

// File: rtl/gpu_rasterizer.sv
// Rasterizes solid rectangles and 1-bit sprites (optional 2x scale) into one clipped
// framebuffer write per enabled cycle.
module gpu_rasterizer #(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned SPRITE_ADDR_WIDTH = 12
) (
  input logic              clk,
  input logic              rst,
  input logic              ce,
  gpu_rasterizer_if.master bus
);
  localparam int unsigned FbAddrWidth = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StDraw, StDrain} state_e;

  state_e                       state_q, state_d;
  logic                         op_rd_en_q, op_rd_en_d;
  logic                         busy_q, busy_d;
  logic                         drain_q, drain_d;
  logic [10:0]                  x_q, x_d, y_q, y_d, width_q, width_d;
  logic                         color_q, color_d, mem_en_q, mem_en_d, scale_q, scale_d;
  logic [SPRITE_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [11:0]                  dw_q, dw_d, dh_q, dh_d, c_q, c_d, r_q, r_d;
  logic [SPRITE_ADDR_WIDTH-1:0] spr_addr_q, spr_addr_d;
  logic                         s2_vld_q, s2_vld_d, s2_mem_en_q, s2_mem_en_d;
  logic                         s2_color_q, s2_color_d;
  logic [FbAddrWidth-1:0]       fb_addr_q, fb_addr_d;

  logic [11:0]                  op_dw, op_dh, px, py, c_nxt, r_nxt;
  logic                         visible, last_col, last_pix;
  logic [SPRITE_ADDR_WIDTH-1:0] spr_nxt;

  assign op_dw    = {1'b0, bus.op.width} << bus.op.scale;
  assign op_dh    = {1'b0, bus.op.height} << bus.op.scale;
  assign px       = {1'b0, x_q} + c_q;
  assign py       = {1'b0, y_q} + r_q;
  assign visible  = (px < 12'(HOR_ACTIVE_PIXELS)) && (py < 12'(VER_ACTIVE_PIXELS));
  assign last_col = (c_q == dw_q - 12'd1);
  assign last_pix = last_col && (r_q == dh_q - 12'd1);
  assign c_nxt    = last_col ? 12'd0 : c_q + 12'd1;
  assign r_nxt    = last_col ? r_q + 12'd1 : r_q;
  // The ROM address is prefetched one pixel ahead so its data meets the stage-2 registers.
  assign spr_nxt  = mem_addr_q
                  + SPRITE_ADDR_WIDTH'(24'(r_nxt >> scale_q) * 24'(width_q))
                  + SPRITE_ADDR_WIDTH'(c_nxt >> scale_q);

  always_comb begin
    state_d     = state_q;
    op_rd_en_d  = 1'b0;
    busy_d      = busy_q;
    drain_d     = drain_q;
    x_d         = x_q;
    y_d         = y_q;
    width_d     = width_q;
    color_d     = color_q;
    mem_en_d    = mem_en_q;
    scale_d     = scale_q;
    mem_addr_d  = mem_addr_q;
    dw_d        = dw_q;
    dh_d        = dh_q;
    c_d         = c_q;
    r_d         = r_q;
    spr_addr_d  = spr_addr_q;
    s2_vld_d    = 1'b0;
    s2_mem_en_d = s2_mem_en_q;
    s2_color_d  = s2_color_q;
    fb_addr_d   = fb_addr_q;

    case (state_q)
      StIdle: begin
        busy_d = !bus.op_empty;
        if (!bus.op_empty) begin
          op_rd_en_d = 1'b1;
          state_d    = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        x_d        = bus.op.x;
        y_d        = bus.op.y;
        width_d    = bus.op.width;
        color_d    = bus.op.color;
        mem_en_d   = bus.op.mem_en;
        scale_d    = bus.op.scale;
        mem_addr_d = bus.op.mem_addr;
        dw_d       = op_dw;
        dh_d       = op_dh;
        c_d        = 12'd0;
        r_d        = 12'd0;
        spr_addr_d = bus.op.mem_addr;
        if (op_dw == 12'd0 || op_dh == 12'd0) begin
          state_d = StIdle;
          busy_d  = !bus.op_empty;
        end else begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        s2_vld_d    = visible;
        s2_mem_en_d = mem_en_q;
        s2_color_d  = color_q;
        fb_addr_d   = FbAddrWidth'(32'(py) * HOR_ACTIVE_PIXELS + 32'(px));
        if (last_pix) begin
          state_d = StDrain;
        end else begin
          c_d        = c_nxt;
          r_d        = r_nxt;
          spr_addr_d = spr_nxt;
        end
      end
      StDrain: begin
        // First cycle retires the last write, second lets the pipeline settle.
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
          state_d = StIdle;
          busy_d  = !bus.op_empty;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_rd_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      drain_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      width_q     <= '0;
      color_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      scale_q     <= 1'b0;
      mem_addr_q  <= '0;
      dw_q        <= '0;
      dh_q        <= '0;
      c_q         <= '0;
      r_q         <= '0;
      spr_addr_q  <= '0;
      s2_vld_q    <= 1'b0;
      s2_mem_en_q <= 1'b0;
      s2_color_q  <= 1'b0;
      fb_addr_q   <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      op_rd_en_q  <= op_rd_en_d;
      busy_q      <= busy_d;
      drain_q     <= drain_d;
      x_q         <= x_d;
      y_q         <= y_d;
      width_q     <= width_d;
      color_q     <= color_d;
      mem_en_q    <= mem_en_d;
      scale_q     <= scale_d;
      mem_addr_q  <= mem_addr_d;
      dw_q        <= dw_d;
      dh_q        <= dh_d;
      c_q         <= c_d;
      r_q         <= r_d;
      spr_addr_q  <= spr_addr_d;
      s2_vld_q    <= s2_vld_d;
      s2_mem_en_q <= s2_mem_en_d;
      s2_color_q  <= s2_color_d;
      fb_addr_q   <= fb_addr_d;
    end
  end

  // Strobes are masked by ce so a frozen cycle never repeats a pop or a write.
  assign bus.op_rd_en       = op_rd_en_q & ce;
  assign bus.busy           = busy_q;
  assign bus.sprite_rd_addr = spr_addr_q;
  assign bus.fb_wr_en       = ce & s2_vld_q & (!s2_mem_en_q | bus.sprite_rd_data[1]);
  assign bus.fb_wr_addr     = fb_addr_q;
  assign bus.fb_wr_data     = s2_mem_en_q ? bus.sprite_rd_data[0] : s2_color_q;
endmodule

// File: tb/tb_gpu_rasterizer.sv
// Self-checking bench: op FIFO and sprite ROM models, table of ops with a pixel scoreboard,
// plus reset, random clock-enable and mid-draw reset sequences.
module tb_gpu_rasterizer;
  localparam int unsigned H   = 640;
  localparam int unsigned V   = 480;
  localparam int unsigned SAW = 12;

  typedef struct packed {
    logic [10:0]    x;
    logic [10:0]    y;
    logic [10:0]    width;
    logic [10:0]    height;
    logic           color;
    logic           mem_en;
    logic [SAW-1:0] mem_addr;
    logic           scale;
  } tb_op_t;

  typedef struct {
    tb_op_t op;
    int     n_wr;
    int     first_addr;
    int     last_addr;
    int     busy_off;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  gpu_rasterizer_if #(
    .HOR_ACTIVE_PIXELS(H),
    .VER_ACTIVE_PIXELS(V),
    .SPRITE_ADDR_WIDTH(SAW)
  ) bus ();

  gpu_rasterizer #(
    .HOR_ACTIVE_PIXELS(H),
    .VER_ACTIVE_PIXELS(V),
    .SPRITE_ADDR_WIDTH(SAW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .bus(bus)
  );

  // Op FIFO: data appears the cycle after the pop.
  tb_op_t fifo_mem [0:31];
  int     wr_ptr = 0;
  int     rd_ptr = 0;
  assign bus.op_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.op_rd_en) begin
      bus.op <= fifo_mem[rd_ptr % 32];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Sprite ROM, one-cycle latency, frozen with ce.
  logic [1:0] rom [0:4095];
  always @(posedge clk) begin
    if (ce) bus.sprite_rd_data <= rom[bus.sprite_rd_addr];
  end

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   wr_cnt, first_wr_cyc, first_addr, last_addr;
  int   pop_cnt = 0;
  int   pop_cyc = -1;
  int   pop_en = 0;
  int   prev_pop_en = 0;
  bit   rand_ce = 1'b0;
  int   exp_addr[$];
  int   exp_data[$];
  vec_t vecs [0:6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    int a, d;
    @(negedge clk);
    cyc++;
    if (ce) en_cyc++;
    if (bus.op_rd_en) begin
      check("pop_not_empty", int'(bus.op_empty), 0);
      check("busy_with_pop", int'(bus.busy), 1);
      pop_cnt++;
      pop_cyc     = cyc;
      prev_pop_en = pop_en;
      pop_en      = en_cyc;
    end
    if (bus.fb_wr_en) begin
      if (wr_cnt == 0) begin
        first_wr_cyc = cyc;
        first_addr   = int'(bus.fb_wr_addr);
      end
      last_addr = int'(bus.fb_wr_addr);
      wr_cnt++;
      if (exp_addr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0d, required no write",
                 bus.fb_wr_addr, bus.fb_wr_data);
      end else begin
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("wr_addr", int'(bus.fb_wr_addr), a);
        check("wr_data", int'(bus.fb_wr_data), d);
      end
    end
    ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  function automatic tb_op_t mk_op(input int x, y, w, h, col, men, addr, sc);
    tb_op_t o;
    o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
    o.color = 1'(col); o.mem_en = 1'(men); o.mem_addr = SAW'(addr); o.scale = 1'(sc);
    return o;
  endfunction

  // Reference: raster-order walk over the destination rectangle.
  task automatic model(input tb_op_t o);
    int dw, dh, px, py, idx;
    logic [1:0] t;
    dw = int'(o.width) << o.scale;
    dh = int'(o.height) << o.scale;
    for (int r = 0; r < dh; r++) begin
      for (int c = 0; c < dw; c++) begin
        px = (int'(o.x) + c) % 4096;
        py = (int'(o.y) + r) % 4096;
        if (px < int'(H) && py < int'(V)) begin
          if (o.mem_en) begin
            idx = (int'(o.mem_addr) + (r >> o.scale) * int'(o.width) + (c >> o.scale)) % 4096;
            t = rom[idx];
            if (t[1]) begin
              exp_addr.push_back(py * int'(H) + px);
              exp_data.push_back(int'(t[0]));
            end
          end else begin
            exp_addr.push_back(py * int'(H) + px);
            exp_data.push_back(int'(o.color));
          end
        end
      end
    end
  endtask

  task automatic push_op(input tb_op_t o);
    fifo_mem[wr_ptr % 32] = o;
    wr_ptr++;
    model(o);
  endtask

  task automatic set_vec(input int i, input tb_op_t o, input int n, fa, la, bo);
    vecs[i].op = o; vecs[i].n_wr = n; vecs[i].first_addr = fa;
    vecs[i].last_addr = la; vecs[i].busy_off = bo;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_op_rd_en"}, int'(bus.op_rd_en), 0);
    check({tag, "_fb_wr_en"}, int'(bus.fb_wr_en), 0);
    check({tag, "_fb_wr_addr"}, int'(bus.fb_wr_addr), 0);
    check({tag, "_fb_wr_data"}, int'(bus.fb_wr_data), 0);
    check({tag, "_sprite_rd_addr"}, int'(bus.sprite_rd_addr), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int fall = -1;
    wr_cnt = 0; first_wr_cyc = -1; first_addr = -1; last_addr = -1; pop_cyc = -1;
    push_op(v.op);
    for (int k = 0; k < 20 && pop_cyc < 0; k++) tick();
    if (pop_cyc < 0) begin
      tests++; fails++;
      $display("FAIL %s_pop_timeout: got no pop, expected one within 20 cycles", tag);
      return;
    end
    for (int k = 0; k < 300 && fall < 0; k++) begin
      tick();
      if (!bus.busy) fall = cyc;
    end
    check({tag, "_n_writes"}, wr_cnt, v.n_wr);
    if (v.n_wr > 0) begin
      check({tag, "_first_latency"}, first_wr_cyc - pop_cyc, 3);
      check({tag, "_first_addr"}, first_addr, v.first_addr);
      check({tag, "_last_addr"}, last_addr, v.last_addr);
    end
    check({tag, "_busy_fall"}, fall - pop_cyc, v.busy_off);
    check({tag, "_sb_empty"}, exp_addr.size(), 0);
  endtask

  initial begin
    int p0;
    int guard;
    for (int i = 0; i < 4096; i++) rom[i] = 2'b00;
    rom[0] = 2'b11; rom[1] = 2'b00; rom[2] = 2'b10; rom[3] = 2'b11;

    set_vec(0, mk_op(10, 5, 4, 2, 1, 0, 0, 0), 8, 3210, 3853, 12);
    set_vec(1, mk_op(638, 479, 4, 2, 1, 0, 0, 0), 2, 307198, 307199, 12);
    set_vec(2, mk_op(0, 0, 2, 2, 0, 1, 0, 0), 3, 0, 641, 8);
    set_vec(3, mk_op(0, 0, 2, 2, 0, 1, 0, 1), 12, 0, 1923, 20);
    set_vec(4, mk_op(20, 20, 0, 3, 1, 0, 0, 0), 0, -1, -1, 2);
    set_vec(5, mk_op(700, 0, 2, 1, 1, 0, 0, 0), 0, -1, -1, 6);
    set_vec(6, mk_op(5, 1, 2, 1, 1, 1, 2, 0), 2, 645, 646, 6);

    // Reset held for three cycles, then idle with an empty FIFO.
    wr_cnt = 0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("reset");
    for (int k = 0; k < 5; k++) tick();
    check("reset_no_pop", pop_cnt, 0);
    check("reset_no_write", wr_cnt, 0);

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Two queued ops with a random clock enable.
    rand_ce = 1'b1;
    wr_cnt = 0;
    p0 = pop_cnt;
    fifo_mem[wr_ptr % 32] = vecs[0].op; wr_ptr++; model(vecs[0].op);
    fifo_mem[wr_ptr % 32] = vecs[2].op; wr_ptr++; model(vecs[2].op);
    guard = 0;
    while (!(pop_cnt - p0 == 2 && !bus.busy) && guard < 800) begin
      tick();
      guard++;
    end
    check("b2b_done", int'(guard < 800), 1);
    check("b2b_n_writes", wr_cnt, 11);
    check("b2b_pop_gap", pop_en - prev_pop_en, 13);
    check("b2b_sb_empty", exp_addr.size(), 0);
    rand_ce = 1'b0;
    tick();

    // Reset in the middle of drawing.
    wr_cnt = 0; pop_cyc = -1;
    push_op(mk_op(0, 10, 20, 2, 1, 0, 0, 0));
    for (int k = 0; k < 20 && pop_cyc < 0; k++) tick();
    for (int k = 0; k < 6; k++) tick();
    check("mid_writing", int'(bus.fb_wr_en), 1);
    #2 rst = 1'b0;
    #1 check_idle_outputs("midrst");
    exp_addr.delete();
    exp_data.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy_after", int'(bus.busy), 0);
    run_op(vecs[0], "restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
